engine_cu_dispatch_scheduler: RTL and testbench

//  Sequences a stride index walk from one StrideIndexConfiguration and deals Vertex-IDs to NUM_CUS compute units.

---
 rtl/engine_cu_dispatch_scheduler_pkg.sv | 46 ++++
 rtl/engine_cu_dispatch_scheduler_cu_round_robin_select.sv | 33 +++
 rtl/engine_cu_dispatch_scheduler.sv | 172 +++++++++++++++++
 tb/tb_engine_cu_dispatch_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_cu_dispatch_scheduler_pkg.sv
// Shared types for the CU dispatch scheduler: walk configuration, packet meta,
// dispatch payload and the stride-index walk state encoding.
package engine_cu_dispatch_scheduler_pkg;

    localparam int M_AXI_MEMORY_ADDR_WIDTH        = 32;
    localparam int ENGINE_CU_DISPATCH_CHUNK_CNT_W = 32;

    typedef struct packed {
        logic [7:0] kernel_id;
        logic [7:0] buffer_id;
    } MemoryPacketMeta;

    typedef struct packed {
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_start;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_end;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] stride;
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] granularity;
        logic                               increment;
        logic                               decrement;
    } StrideIndexParameters;

    typedef struct packed {
        logic                 valid;
        StrideIndexParameters param;
        MemoryPacketMeta      meta;
    } StrideIndexConfiguration;

    typedef struct packed {
        logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index;
        logic                               last;
        MemoryPacketMeta                    meta;
    } EngineCUDispatchPayload;

    typedef enum logic [3:0] {
        ENGINE_STRIDE_INDEX_RESET,
        ENGINE_STRIDE_INDEX_IDLE,
        ENGINE_STRIDE_INDEX_SETUP,
        ENGINE_STRIDE_INDEX_START,
        ENGINE_STRIDE_INDEX_START_TRANS,
        ENGINE_STRIDE_INDEX_BUSY,
        ENGINE_STRIDE_INDEX_PAUSE_TRANS,
        ENGINE_STRIDE_INDEX_PAUSE,
        ENGINE_STRIDE_INDEX_DONE
    } engine_stride_index_state;

endpackage

// File: rtl/engine_cu_dispatch_scheduler_cu_round_robin_select.sv
// Combinational round-robin pick: first ready CU strictly after the pointer,
// wrapping back to the pointer itself last.
module cu_round_robin_select #(
    parameter int NUM_CUS = 4,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_CUS-1:0] i_ready,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_CUS-1:0] o_grant,
    output logic               o_any_ready
);

    logic w_found;

    always_comb begin
        o_grant     = '0;
        w_found     = 1'b0;
        o_any_ready = |i_ready;
        for (int k = 0; k < NUM_CUS; k++) begin
            if (!w_found && i_ready[k] && (k > int'(i_rr_ptr))) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CUS; k++) begin
            if (!w_found && i_ready[k] && (k <= int'(i_rr_ptr))) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/engine_cu_dispatch_scheduler.sv
// Walks a strided index range and deals granularity-sized chunks of Vertex-IDs
// round-robin across NUM_CUS compute units with valid/ready handshakes.
module engine_cu_dispatch_scheduler
    import engine_cu_dispatch_scheduler_pkg::*;
#(
    parameter int NUM_CUS     = 4,
    parameter int ADDR_WIDTH  = M_AXI_MEMORY_ADDR_WIDTH,
    parameter int CU_ID_WIDTH = $clog2(NUM_CUS) + 1
) (
    input  logic                                      ap_clk,
    input  logic                                      areset,
    input  StrideIndexConfiguration                   config_in,
    output logic                                      config_ready,
    input  logic                                      start_in,
    input  logic                                      pause_in,
    output logic [NUM_CUS-1:0]                        dispatch_valid,
    input  logic [NUM_CUS-1:0]                        dispatch_ready,
    output logic [ADDR_WIDTH-1:0]                     dispatch_index,
    output logic                                      dispatch_last,
    output MemoryPacketMeta                           dispatch_meta,
    output logic [CU_ID_WIDTH-1:0]                    dispatch_cu_id,
    output logic                                      busy_out,
    output logic                                      done_out,
    output logic [ENGINE_CU_DISPATCH_CHUNK_CNT_W-1:0] chunks_out
);

    engine_stride_index_state r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]  r_index, r_index_end, r_stride, r_gran, r_chunk_cnt;
    logic                   r_incr, r_decr, r_finished, r_in_chunk;
    logic [NUM_CUS-1:0]     r_valid, r_cur_cu, w_grant, w_target;
    logic [CU_ID_WIDTH-1:0] r_rr, r_cu_id, w_target_id;
    EngineCUDispatchPayload r_payload;
    MemoryPacketMeta        r_meta;
    logic                   r_config_ready, r_busy, r_done;
    logic [ENGINE_CU_DISPATCH_CHUNK_CNT_W-1:0] r_chunks;

    logic [ADDR_WIDTH:0] w_next;
    logic w_any_ready, w_beat, w_slot_free, w_next_finished, w_issue_last, w_issue;
    logic w_setup_finished;

    cu_round_robin_select #(.NUM_CUS(NUM_CUS), .PTR_W(CU_ID_WIDTH)) u_rr_select (
        .i_ready     (dispatch_ready),
        .i_rr_ptr    (r_rr),
        .o_grant     (w_grant),
        .o_any_ready (w_any_ready)
    );

    // One extra bit on the step so a carry/borrow ends the walk instead of wrapping.
    always_comb begin
        w_next = r_incr ? ({1'b0, r_index} + {1'b0, r_stride})
                        : ({1'b0, r_index} - {1'b0, r_stride});
        w_next_finished = w_next[ADDR_WIDTH] ||
                          (r_incr ? (w_next[ADDR_WIDTH-1:0] >= r_index_end)
                                  : (w_next[ADDR_WIDTH-1:0] <= r_index_end));
        w_setup_finished = (r_stride == '0) || !(r_incr || r_decr) ||
                           (r_incr ? (r_index >= r_index_end) : (r_index <= r_index_end));
        w_issue_last = (r_chunk_cnt == r_gran - ADDR_WIDTH'(1)) || w_next_finished;
        w_beat       = |(r_valid & dispatch_ready);
        w_slot_free  = (r_valid == '0) || w_beat;
        w_target     = r_in_chunk ? r_cur_cu : w_grant;
        w_issue      = (r_state == ENGINE_STRIDE_INDEX_BUSY) && !pause_in && w_slot_free &&
                       !r_finished && (r_in_chunk || w_any_ready);
        w_target_id  = '0;
        for (int k = 0; k < NUM_CUS; k++) begin
            if (w_target[k]) w_target_id = CU_ID_WIDTH'(k);
        end
    end

    // NOTE: next-state defaults to the current state before the case, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ENGINE_STRIDE_INDEX_RESET:       w_state_next = ENGINE_STRIDE_INDEX_IDLE;
            ENGINE_STRIDE_INDEX_IDLE:        if (config_in.valid) w_state_next = ENGINE_STRIDE_INDEX_SETUP;
            ENGINE_STRIDE_INDEX_SETUP:       w_state_next = ENGINE_STRIDE_INDEX_START;
            ENGINE_STRIDE_INDEX_START:       if (start_in) w_state_next = ENGINE_STRIDE_INDEX_START_TRANS;
            ENGINE_STRIDE_INDEX_START_TRANS: w_state_next = (r_finished && r_valid == '0)
                                                 ? ENGINE_STRIDE_INDEX_DONE : ENGINE_STRIDE_INDEX_BUSY;
            ENGINE_STRIDE_INDEX_BUSY: begin
                if (pause_in)                       w_state_next = ENGINE_STRIDE_INDEX_PAUSE_TRANS;
                else if (r_finished && w_slot_free) w_state_next = ENGINE_STRIDE_INDEX_DONE;
            end
            ENGINE_STRIDE_INDEX_PAUSE_TRANS: if (w_slot_free) w_state_next = ENGINE_STRIDE_INDEX_PAUSE;
            ENGINE_STRIDE_INDEX_PAUSE:       if (!pause_in) w_state_next = ENGINE_STRIDE_INDEX_START_TRANS;
            ENGINE_STRIDE_INDEX_DONE:        if (!start_in) w_state_next = ENGINE_STRIDE_INDEX_IDLE;
            default:                         w_state_next = ENGINE_STRIDE_INDEX_RESET;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            r_state        <= ENGINE_STRIDE_INDEX_RESET;
            r_index        <= '0;
            r_index_end    <= '0;
            r_stride       <= '0;
            r_gran         <= '0;
            r_chunk_cnt    <= '0;
            r_incr         <= 1'b0;
            r_decr         <= 1'b0;
            r_finished     <= 1'b0;
            r_in_chunk     <= 1'b0;
            r_valid        <= '0;
            r_cur_cu       <= '0;
            r_rr           <= CU_ID_WIDTH'(NUM_CUS - 1);
            r_cu_id        <= '0;
            r_payload      <= '0;
            r_meta         <= '0;
            r_config_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_chunks       <= '0;
        end else begin
            r_state        <= w_state_next;
            r_config_ready <= (w_state_next == ENGINE_STRIDE_INDEX_IDLE);
            r_done         <= (w_state_next == ENGINE_STRIDE_INDEX_DONE);
            r_busy         <= (w_state_next == ENGINE_STRIDE_INDEX_START_TRANS) ||
                              (w_state_next == ENGINE_STRIDE_INDEX_BUSY) ||
                              (w_state_next == ENGINE_STRIDE_INDEX_PAUSE_TRANS) ||
                              (w_state_next == ENGINE_STRIDE_INDEX_PAUSE);

            if (r_state == ENGINE_STRIDE_INDEX_IDLE && config_in.valid) begin
                r_index     <= config_in.param.index_start;
                r_index_end <= config_in.param.index_end;
                r_stride    <= config_in.param.stride;
                r_gran      <= (config_in.param.granularity == '0) ? ADDR_WIDTH'(1)
                                                                   : config_in.param.granularity;
                r_incr      <= config_in.param.increment;
                r_decr      <= config_in.param.decrement;
                r_meta      <= config_in.meta;
            end

            if (r_state == ENGINE_STRIDE_INDEX_SETUP) begin
                r_chunk_cnt <= '0;
                r_finished  <= w_setup_finished;
                r_in_chunk  <= 1'b0;
                r_chunks    <= '0;
            end

            if (w_issue) begin
                r_payload.index <= r_index;
                r_payload.last  <= w_issue_last;
                r_payload.meta  <= r_meta;
                r_cu_id         <= w_target_id;
                r_index         <= w_next[ADDR_WIDTH-1:0];
                r_finished      <= w_next_finished;
                r_chunk_cnt     <= w_issue_last ? '0 : r_chunk_cnt + ADDR_WIDTH'(1);
                r_in_chunk      <= !w_issue_last;
                if (!r_in_chunk) begin
                    r_cur_cu <= w_target;
                    r_rr     <= w_target_id;
                end
            end

            if (w_issue)     r_valid <= w_target;
            else if (w_beat) r_valid <= '0;

            if (w_beat && r_payload.last && (r_chunks != '1)) r_chunks <= r_chunks + 1'b1;
        end
    end

    assign config_ready   = r_config_ready;
    assign dispatch_valid = r_valid;
    assign dispatch_index = r_payload.index;
    assign dispatch_last  = r_payload.last;
    assign dispatch_meta  = r_payload.meta;
    assign dispatch_cu_id = r_cu_id;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign chunks_out     = r_chunks;

endmodule

// File: tb/tb_engine_cu_dispatch_scheduler.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and
// compares every handshake the scheduler completes.
module tb_engine_cu_dispatch_scheduler;
    import engine_cu_dispatch_scheduler_pkg::*;

    localparam int NC = 4;

    logic                    ap_clk = 1'b0;
    logic                    areset = 1'b1;
    StrideIndexConfiguration config_in = '0;
    logic                    config_ready;
    logic                    start_in = 1'b0;
    logic                    pause_in = 1'b0;
    logic [NC-1:0]           dispatch_valid;
    logic [NC-1:0]           dispatch_ready = '1;
    logic [31:0]             dispatch_index;
    logic                    dispatch_last;
    MemoryPacketMeta         dispatch_meta;
    logic [2:0]              dispatch_cu_id;
    logic                    busy_out, done_out;
    logic [31:0]             chunks_out;

    engine_cu_dispatch_scheduler #(.NUM_CUS(NC)) dut (
        .ap_clk         (ap_clk),
        .areset         (areset),
        .config_in      (config_in),
        .config_ready   (config_ready),
        .start_in       (start_in),
        .pause_in       (pause_in),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .dispatch_index (dispatch_index),
        .dispatch_last  (dispatch_last),
        .dispatch_meta  (dispatch_meta),
        .dispatch_cu_id (dispatch_cu_id),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .chunks_out     (chunks_out)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int          cu;
        logic [31:0] index;
        logic        last;
        logic [15:0] meta;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          beat_count = 0;
    logic [15:0] cur_meta = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int cu, input logic [31:0] idx, input logic last);
        exp_t e;
        e.cu = cu; e.index = idx; e.last = last; e.meta = cur_meta;
        sb_q.push_back(e);
    endtask

    // Monitor: handshake seen at the negedge completes at the following posedge.
    logic [NC-1:0] prev_valid;
    logic [31:0]   prev_index;
    logic          prev_pend = 1'b0;
    always @(negedge ap_clk) begin
        if (areset) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                check("hold_valid", 64'(dispatch_valid), 64'(prev_valid));
                check("hold_index", 64'(dispatch_index), 64'(prev_index));
            end
            if ($countones(dispatch_valid) > 1) check("valid_onehot", 64'(dispatch_valid), 64'(0));
            if (|(dispatch_valid & dispatch_ready)) begin
                beat_count++;
                if (sb_q.size() == 0) begin
                    check("unexpected_beat_index", 64'(dispatch_index), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("beat_valid", 64'(dispatch_valid), 64'(1) << e.cu);
                    check("beat_cu_id", 64'(dispatch_cu_id), 64'(e.cu));
                    check("beat_index", 64'(dispatch_index), 64'(e.index));
                    check("beat_last",  64'(dispatch_last),  64'(e.last));
                    check("beat_meta",  64'(dispatch_meta),  64'(e.meta));
                end
            end
            prev_pend  = (|dispatch_valid) && !(|(dispatch_valid & dispatch_ready));
            prev_valid = dispatch_valid;
            prev_index = dispatch_index;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},  64'(dispatch_valid), 64'(0));
        check({tag, "_index"},  64'(dispatch_index), 64'(0));
        check({tag, "_flags"},  64'({dispatch_last, busy_out, done_out, config_ready}), 64'(0));
        check({tag, "_cuid"},   64'({dispatch_cu_id, dispatch_meta}), 64'(0));
        check({tag, "_chunks"}, 64'(chunks_out), 64'(0));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        start_in = 1'b0;
        pause_in = 1'b0;
        config_in.valid = 1'b0;
        areset = 1'b1;
        #1;
        check_outputs_zero(tag);
        sb_q.delete();
        @(posedge ap_clk); #1;
        areset = 1'b0;
        @(posedge ap_clk); #1;
        check({tag, "_idle_ready"}, 64'(config_ready), 64'(1));
    endtask

    task automatic configure(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [31:0] g, input logic inc, input logic dec);
        int c;
        c = 0;
        while (!config_ready && c < 20) begin @(posedge ap_clk); #1; c++; end
        if (!config_ready) check("cfg_ready_timeout", 64'(config_ready), 64'(1));
        config_in.valid             = 1'b1;
        config_in.param.index_start = s;
        config_in.param.index_end   = e;
        config_in.param.stride      = st;
        config_in.param.granularity = g;
        config_in.param.increment   = inc;
        config_in.param.decrement   = dec;
        config_in.meta              = cur_meta;
        @(posedge ap_clk); #1;
        config_in.valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!done_out && cycles < limit) begin @(posedge ap_clk); #1; cycles++; end
        if (!done_out) check("done_timeout", 64'(done_out), 64'(1));
    endtask

    task automatic finish_walk(input string name, input int exp_chunks);
        check({name, "_chunks"}, 64'(chunks_out), 64'(exp_chunks));
        check({name, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
        start_in = 1'b0;
        @(posedge ap_clk); #1;
        check({name, "_back_idle"}, 64'({config_ready, done_out}), 64'(2'b10));
    endtask

    task automatic run_walk(input string name, input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] st, input logic [31:0] g, input logic inc,
                            input logic dec, input int exp_chunks, input bit quick);
        int cyc;
        int bc;
        bc = beat_count;
        configure(s, e, st, g, inc, dec);
        start_in = 1'b1;
        wait_done(quick ? 8 : 600, cyc);
        if (quick) begin
            check({name, "_done_latency_le4"}, 64'(cyc <= 4), 64'(1));
            check({name, "_zero_beats"}, 64'(beat_count - bc), 64'(0));
        end
        finish_walk(name, exp_chunks);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d beats seen", beat_count);
        $fatal(1);
    end

    initial begin
        int bc0, bc1;

        do_reset("reset0");

        // 1: four full chunks, one per CU
        cur_meta = 16'h1101;
        for (int i = 0; i < 16; i++) push_exp(i / 4, i, (i % 4) == 3);
        run_walk("t1", 0, 16, 1, 4, 1'b1, 1'b0, 4, 1'b0);

        // 2: CU1 never ready, skipped by the scan
        do_reset("reset2");
        cur_meta = 16'h2202;
        dispatch_ready = 4'b1101;
        push_exp(0, 0, 0); push_exp(0, 2, 1);
        push_exp(2, 4, 0); push_exp(2, 6, 1);
        push_exp(3, 8, 1);
        run_walk("t2", 0, 10, 2, 2, 1'b1, 1'b0, 3, 1'b0);
        dispatch_ready = '1;

        // 3: decrementing walk in a single short chunk
        do_reset("reset3");
        cur_meta = 16'h3303;
        push_exp(0, 20, 0); push_exp(0, 15, 0); push_exp(0, 10, 1);
        run_walk("t3", 20, 5, 5, 8, 1'b0, 1'b1, 1, 1'b0);

        // 4: pause while CU0 stalls mid-chunk
        do_reset("reset4");
        cur_meta = 16'h4404;
        dispatch_ready = 4'b0001;
        for (int i = 0; i < 100; i++) push_exp((i / 4) % 4, i, (i % 4) == 3);
        configure(0, 100, 1, 4, 1'b1, 1'b0);
        start_in = 1'b1;
        bc0 = beat_count;
        for (int c = 0; c < 50 && beat_count < bc0 + 2; c++) begin @(posedge ap_clk); #1; end
        dispatch_ready = 4'b0000;
        pause_in = 1'b1;
        repeat (3) begin @(posedge ap_clk); #1; end
        check("t4_stall_valid", 64'(dispatch_valid), 64'(4'b0001));
        check("t4_stall_index", 64'(dispatch_index), 64'(2));
        check("t4_busy", 64'(busy_out), 64'(1));
        bc1 = beat_count;
        dispatch_ready = 4'b0001;
        repeat (6) begin @(posedge ap_clk); #1; end
        check("t4_pause_one_beat", 64'(beat_count - bc1), 64'(1));
        check("t4_pause_no_valid", 64'(dispatch_valid), 64'(0));
        dispatch_ready = '1;
        pause_in = 1'b0;
        wait_done(600, bc1);
        finish_walk("t4", 25);

        // 5: degenerate walks and granularity 0
        do_reset("reset5");
        cur_meta = 16'h5505;
        run_walk("t5_stride0", 0, 10, 0, 4, 1'b1, 1'b0, 0, 1'b1);
        run_walk("t5_empty",   10, 10, 1, 4, 1'b1, 1'b0, 0, 1'b1);
        run_walk("t5_nodir",   0, 10, 1, 4, 1'b0, 1'b0, 0, 1'b1);
        push_exp(0, 0, 1); push_exp(1, 1, 1); push_exp(2, 2, 1);
        run_walk("t5_gran0",   0, 3, 1, 0, 1'b1, 1'b0, 3, 1'b0);

        // 6: end-of-range carry/borrow, pointer carried between walks, async reset
        do_reset("reset6");
        cur_meta = 16'h6606;
        push_exp(0, 32'hFFFF_FFFD, 1);
        run_walk("t6_top", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 4, 1'b1, 1'b0, 1, 1'b0);
        push_exp(1, 32'hFFFF_FFFD, 1);
        run_walk("t6_carry", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4, 4, 1'b1, 1'b0, 1, 1'b0);
        push_exp(2, 3, 1);
        run_walk("t6_borrow", 3, 0, 4, 4, 1'b0, 1'b1, 1, 1'b0);

        do_reset("reset7");
        cur_meta = 16'h7707;
        for (int i = 0; i < 40; i++) push_exp((i / 4) % 4, i, (i % 4) == 3);
        configure(0, 40, 1, 4, 1'b1, 1'b0);
        start_in = 1'b1;
        bc0 = beat_count;
        for (int c = 0; c < 50 && beat_count < bc0 + 6; c++) begin @(posedge ap_clk); #1; end
        check("t6_busy_before_reset", 64'(busy_out), 64'(1));
        do_reset("t6_midbusy");
        bc1 = beat_count;
        repeat (5) begin @(posedge ap_clk); #1; end
        check("t6_no_beats_after_reset", 64'(beat_count - bc1), 64'(0));
        check("t6_chunks_after_reset", 64'(chunks_out), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
